// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: FSM state type, default data width and
// an elaboration-time ceil(log2) helper.
package cpu_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++)
            if ((32'd1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: first set req bit after position last,
// wrapping modulo NUM_REQ.
module rr_priority_sel
    import cpu_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] sel,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    assign any_req = |req;

    always_comb begin
        int unsigned w_pos;
        logic        w_found;
        sel     = '0;
        idx     = '0;
        w_pos   = 0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_pos = (32'(last) + k) % NUM_REQ;
            if (!w_found && req[w_pos[IDX_W-1:0]]) begin
                w_found                 = 1'b1;
                sel[w_pos[IDX_W-1:0]]   = 1'b1;
                idx                     = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register write port among NUM_REQ
// requesters, with one-cycle write, readback verify and acknowledge.
module reg_write_arbiter
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      ack_err,
    output logic                      busy,
    output logic                      reg_enable,
    output logic [DATA_W-1:0]         reg_data_in,
    input  logic [DATA_W-1:0]         reg_data_out,
    output logic [ERRCNT_W-1:0]       err_count
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);

    state_t               r_state;
    logic [IDX_W-1:0]     r_last;
    logic [NUM_REQ-1:0]   r_gsel;
    logic [NUM_REQ-1:0]   w_sel;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_mismatch;

    rr_priority_sel #(
        .NUM_REQ (NUM_REQ)
    ) u_sel (
        .req     (req),
        .last    (r_last),
        .sel     (w_sel),
        .idx     (w_idx),
        .any_req (w_any)
    );

    // reg_data_in doubles as the captured write data (wdata) for the readback compare
    assign w_mismatch = (reg_data_out != reg_data_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_gsel      <= '0;
            ack         <= '0;
            ack_err     <= 1'b0;
            busy        <= 1'b0;
            reg_enable  <= 1'b0;
            reg_data_in <= '0;
            err_count   <= '0;
        end else begin
            ack        <= '0;
            ack_err    <= 1'b0;
            reg_enable <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gsel      <= w_sel;
                        r_last      <= w_idx;
                        reg_data_in <= req_data[w_idx*DATA_W +: DATA_W];
                        reg_enable  <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_CHECK;
                end
                // Ack is registered on leaving CHECK so ack_err reflects the readback seen during CHECK
                ST_CHECK: begin
                    ack     <= r_gsel;
                    ack_err <= w_mismatch;
                    if (w_mismatch && (err_count != '1))
                        err_count <= err_count + ERRCNT_W'(1);
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
